// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - CAN frame layout, CRC-15 helpers and FIFO entry type
package can_pkg;

    localparam int FRAME_W  = 134;
    localparam int SOF_BIT  = 133;
    localparam int ID_MSB   = 132;
    localparam int ID_LSB   = 122;
    localparam int RTR_BIT  = 121;
    localparam int IDE_BIT  = 120;
    localparam int R0_BIT   = 119;
    localparam int DLC_MSB  = 118;
    localparam int DLC_LSB  = 115;
    localparam int DATA_MSB = 114;
    localparam int DATA_LSB = 51;
    localparam int CRC_MSB  = 50;
    localparam int CRC_LSB  = 36;
    // SOF + ID + RTR + IDE + r0 + DLC, always covered by the CRC
    localparam int HDR_BITS = 19;

    localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

    typedef struct packed {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } can_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } can_state_t;

    // One serial CRC-15 step, MSB-first
    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        logic [14:0] nxt;
        nxt = {crc[13:0], 1'b0};
        if (b ^ crc[14]) begin
            nxt = nxt ^ CAN_CRC_POLY;
        end
        return nxt;
    endfunction

    // Number of data bytes actually carried on the bus
    function automatic logic [3:0] eff_len(input logic rtr, input logic [3:0] dlc);
        if (rtr) begin
            return 4'd0;
        end else if (dlc > 4'd8) begin
            return 4'd8;
        end
        return dlc;
    endfunction

    // Keeps the first len bytes (byte 0 at the MSB end), zeroes the rest
    function automatic logic [63:0] data_mask(input logic [3:0] len);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < len) begin
                m[63 - 8*i -: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/can_frame_buffer_if.sv
// rtl/can_frame_buffer_if.sv - readout handshake between frame buffer and consumer
interface can_frame_buffer_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [10:0] rd_id;
    logic        rd_rtr;
    logic [3:0]  rd_dlc;
    logic [63:0] rd_data;

    modport master (
        output rd_valid, rd_id, rd_rtr, rd_dlc, rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_id, rd_rtr, rd_dlc, rd_data,
        output rd_ready
    );
endinterface

// File: rtl/can_frame_fifo.sv
// rtl/can_frame_fifo.sv - DEPTH-entry FIFO of accepted frames with registered head
module can_frame_fifo
    import can_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  can_entry_t push_entry,
    input  logic       pop_ready,
    output logic       full,
    output logic       pop,
    output logic       head_valid,
    output can_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    can_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             head_valid_q, head_valid_d;
    can_entry_t       head_q, head_d;
    logic             push_ok;

    assign pop        = head_valid_q & pop_ready;
    assign full       = (occ_q == OCC_W'(DEPTH));
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign push_ok    = push & (~full | pop);
    assign head_valid = head_valid_q;
    assign head       = head_q;

    // Pointer/occupancy bookkeeping and the next head entry
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        occ_d        = occ_q + OCC_W'(push_ok) - OCC_W'(pop);
        head_valid_d = (occ_d != '0);
        head_d       = head_q;
        if (pop || (push_ok && occ_q == '0)) begin
            if (occ_d == '0) begin
                head_d = '0;
            end else if ((occ_q - OCC_W'(pop)) == '0) begin
                // the new head is the entry being written this cycle
                head_d = push_entry;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    // Entry storage, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/can_frame_buffer.sv
// rtl/can_frame_buffer.sv - CRC-checking CAN receive frame buffer (option: CAN_FRAME_BUFFER_FILTER_EN)
module can_frame_buffer
    import can_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame,
    output logic               busy,
`ifdef CAN_FRAME_BUFFER_FILTER_EN
    input  logic [10:0]        flt_id,
    input  logic [10:0]        flt_mask,
`endif
    can_frame_buffer_if.master rd,
    output logic [CNT_W-1:0]   crc_err_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    can_state_t         state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [14:0]        crc_q, crc_d;
    logic [6:0]         bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   crc_err_q, crc_err_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W:0]     crc_err_sum, drop_sum;
    logic [1:0]         drop_inc;
    logic               err_inc;
    logic               check_drop;
    logic               strobe_drop;
    logic [6:0]         n_bits;
    logic [7:0]         bit_idx;
    logic [3:0]         len;
    logic               flt_pass;
    logic               fifo_push, fifo_full, fifo_pop, head_valid;
    can_entry_t         entry, head;

    assign len     = eff_len(frame_q[RTR_BIT], frame_q[DLC_MSB:DLC_LSB]);
    assign n_bits  = 7'(HDR_BITS) + {len, 3'b000};
    assign bit_idx = 8'(SOF_BIT) - {1'b0, bit_cnt_q};
    assign busy    = (state_q != ST_IDLE);

    assign entry.id   = frame_q[ID_MSB:ID_LSB];
    assign entry.rtr  = frame_q[RTR_BIT];
    assign entry.dlc  = frame_q[DLC_MSB:DLC_LSB];
    assign entry.data = frame_q[DATA_MSB:DATA_LSB] & data_mask(len);

`ifdef CAN_FRAME_BUFFER_FILTER_EN
    assign flt_pass = (((frame_q[ID_MSB:ID_LSB] ^ flt_id) & flt_mask) == 11'd0);
`else
    assign flt_pass = 1'b1;
`endif

    // Receive FSM: latch, serial CRC over the covered bits, then accept/reject
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        crc_d       = crc_q;
        bit_cnt_d   = bit_cnt_q;
        err_inc     = 1'b0;
        check_drop  = 1'b0;
        fifo_push   = 1'b0;
        strobe_drop = frame_valid && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    frame_d   = frame;
                    crc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                crc_d     = crc15_step(crc_q, frame_q[bit_idx]);
                bit_cnt_d = bit_cnt_q + 7'd1;
                if (bit_cnt_q == n_bits - 7'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (crc_q != frame_q[CRC_MSB:CRC_LSB]) begin
                    err_inc = 1'b1;
                end else if (flt_pass) begin
                    if (!fifo_full || fifo_pop) begin
                        fifo_push = 1'b1;
                    end else begin
                        check_drop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // a rejected strobe and a full-FIFO drop can land on the same edge
        drop_inc    = {1'b0, check_drop} + {1'b0, strobe_drop};
        drop_sum    = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);
        drop_d      = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        crc_err_sum = {1'b0, crc_err_q} + (CNT_W+1)'(err_inc);
        crc_err_d   = crc_err_sum[CNT_W] ? '1 : crc_err_sum[CNT_W-1:0];
    end

    // FSM, frame latch, CRC and diagnostic counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            crc_q     <= '0;
            bit_cnt_q <= '0;
            crc_err_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_d;
            crc_err_q <= crc_err_d;
            drop_q    <= drop_d;
        end
    end

    assign crc_err_cnt = crc_err_q;
    assign drop_cnt    = drop_q;

    can_frame_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (entry),
        .pop_ready  (rd.rd_ready),
        .full       (fifo_full),
        .pop        (fifo_pop),
        .head_valid (head_valid),
        .head       (head)
    );

    assign rd.rd_valid = head_valid;
    assign rd.rd_id    = head.id;
    assign rd.rd_rtr   = head.rtr;
    assign rd.rd_dlc   = head.dlc;
    assign rd.rd_data  = head.data;

endmodule

// File: tb/tb_can_frame_buffer.sv
// tb/tb_can_frame_buffer.sv - randomized scoreboard bench for can_frame_buffer
module tb_can_frame_buffer;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_valid;
    logic [133:0]      frame;
    logic              busy;
    logic [CNT_W-1:0]  crc_err_cnt;
    logic [CNT_W-1:0]  drop_cnt;
`ifdef CAN_FRAME_BUFFER_FILTER_EN
    logic [10:0]       flt_id;
    logic [10:0]       flt_mask;
`endif

    can_frame_buffer_if bus ();

    int   ready_mode;
    logic ready_force;
    logic rnd_ready;

    exp_t exp_q[$];
    int   rd_idx;
    int   n_chk, n_fail, m_chk, m_fail;
    int   exp_err, exp_drop;

    always #5 clk = ~clk;

    assign bus.rd_ready = (ready_mode == 1) ? rnd_ready :
                          (ready_mode == 2) ? 1'b1 :
                          (ready_mode == 3) ? ready_force : 1'b0;

    can_frame_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame       (frame),
        .busy        (busy),
`ifdef CAN_FRAME_BUFFER_FILTER_EN
        .flt_id      (flt_id),
        .flt_mask    (flt_mask),
`endif
        .rd          (bus),
        .crc_err_cnt (crc_err_cnt),
        .drop_cnt    (drop_cnt)
    );

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: every handshake pops the oldest expected entry
    always @(negedge clk) begin
        if (!rst && bus.rd_valid && bus.rd_ready) begin
            m_chk++;
            if (rd_idx >= exp_q.size()) begin
                m_fail++;
                $display("FAIL pop_unexpected: got id=%h data=%h, required no entry", bus.rd_id, bus.rd_data);
            end else begin
                if ({bus.rd_id, bus.rd_rtr, bus.rd_dlc, bus.rd_data} !==
                    {exp_q[rd_idx].id, exp_q[rd_idx].rtr, exp_q[rd_idx].dlc, exp_q[rd_idx].data}) begin
                    m_fail++;
                    $display("FAIL pop_entry[%0d]: got id=%h rtr=%b dlc=%h data=%h, required id=%h rtr=%b dlc=%h data=%h",
                             rd_idx, bus.rd_id, bus.rd_rtr, bus.rd_dlc, bus.rd_data,
                             exp_q[rd_idx].id, exp_q[rd_idx].rtr, exp_q[rd_idx].dlc, exp_q[rd_idx].data);
                end
                rd_idx++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int pending();
        return exp_q.size() - rd_idx;
    endfunction

    function automatic int data_len(input logic rtr, input logic [3:0] dlc);
        if (rtr) return 0;
        return (int'(dlc) > 8) ? 8 : int'(dlc);
    endfunction

    function automatic bit flt_ok(input logic [10:0] id);
`ifdef CAN_FRAME_BUFFER_FILTER_EN
        return ((id ^ flt_id) & flt_mask) == 11'd0;
`else
        return 1'b1;
`endif
    endfunction

    // Builds a frame; CRC from polynomial long division of the covered bits
    function automatic logic [133:0] mk_frame(input logic [10:0] id, input logic rtr, input logic ide,
                                              input logic [3:0] dlc, input logic [63:0] data, input int bad_bit);
        logic [133:0] f;
        logic         arr [0:112];
        logic [15:0]  gen;
        logic [14:0]  crc;
        int           n;
        gen = 16'hC599;
        f = '0;
        f[132:122] = id;
        f[121]     = rtr;
        f[120]     = ide;
        f[118:115] = dlc;
        f[114:51]  = data;
        f[35:0]    = 36'({$urandom(), $urandom()});
        n = 19 + 8 * data_len(rtr, dlc);
        for (int i = 0; i < n; i++) arr[i] = f[133 - i];
        for (int i = n; i < n + 15; i++) arr[i] = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (arr[i]) begin
                for (int j = 0; j < 16; j++) arr[i + j] = arr[i + j] ^ gen[15 - j];
            end
        end
        for (int k = 0; k < 15; k++) crc[14 - k] = arr[n + k];
        f[50:36] = crc;
        if (bad_bit >= 0) f[36 + bad_bit] = ~f[36 + bad_bit];
        return f;
    endfunction

    function automatic exp_t mk_exp(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                                    input logic [63:0] data);
        exp_t e;
        int   l;
        l = data_len(rtr, dlc);
        e.id  = id;
        e.rtr = rtr;
        e.dlc = dlc;
        e.data = (l == 0) ? 64'd0 : ((data >> (64 - 8 * l)) << (64 - 8 * l));
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [133:0] f);
        frame = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    // Model outcome of one frame processed from IDLE with FIFO room
    task automatic model_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data, input int bad_bit);
        if (bad_bit >= 0) begin
            if (exp_err < CNT_MAX) exp_err++;
        end else if (flt_ok(id)) begin
            exp_q.push_back(mk_exp(id, rtr, dlc, data));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_err  = 0;
        exp_drop = 0;
    endtask

    task automatic drain(input string nm);
        int b;
        ready_mode = 2;
        b = 0;
        while (pending() != 0 && b < 2000) begin
            tick();
            b++;
        end
        tick();
        chk({nm, "_drained"}, 64'(pending()), 64'd0);
        chk({nm, "_rd_valid_after_drain"}, 64'(bus.rd_valid), 64'd0);
        ready_mode = 0;
    endtask

    task automatic chk_cnts(input string nm);
        chk({nm, "_crc_err_cnt"}, 64'(crc_err_cnt), 64'(exp_err));
        chk({nm, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    initial begin
        logic [133:0] f;
        logic [10:0]  id;
        logic         rtr;
        logic [3:0]   dlc;
        logic [63:0]  data;
        int           n, bad, b, acc, strobes;

        n_chk = 0; n_fail = 0; m_chk = 0; m_fail = 0; rd_idx = 0;
        exp_err = 0; exp_drop = 0;
        rst = 1'b1; frame_valid = 1'b0; frame = '0;
        ready_mode = 0; ready_force = 1'b0;
`ifdef CAN_FRAME_BUFFER_FILTER_EN
        flt_id = '0; flt_mask = '0;
`endif
        tick();
        do_reset();

        // Reset state
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("reset_rd_id", 64'(bus.rd_id), 64'd0);
        chk("reset_rd_rtr", 64'(bus.rd_rtr), 64'd0);
        chk("reset_rd_dlc", 64'(bus.rd_dlc), 64'd0);
        chk("reset_rd_data", bus.rd_data, 64'd0);
        chk_cnts("reset");

        // Good frame: busy window and rd_valid latency
        data = 64'hABCD_0000_0000_0000;
        f = mk_frame(11'h123, 1'b0, 1'b0, 4'd2, data, -1);
        n = 35;
        send(f);
        model_frame(11'h123, 1'b0, 4'd2, data, -1);
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            chk($sformatf("good_busy_T+%0d", k), 64'(busy), 64'(k <= n + 1));
            chk($sformatf("good_rd_valid_T+%0d", k), 64'(bus.rd_valid), 64'(k == n + 2));
        end
        chk("good_rd_id", 64'(bus.rd_id), 64'h123);
        chk("good_rd_dlc", 64'(bus.rd_dlc), 64'd2);
        chk("good_rd_data", bus.rd_data, 64'hABCD_0000_0000_0000);
        tick();
        drain("good");

        // Same frame with CRC bit 36 flipped
        do_reset();
        send(mk_frame(11'h123, 1'b0, 1'b0, 4'd2, data, 0));
        model_frame(11'h123, 1'b0, 4'd2, data, 0);
        repeat (n + 3) tick();
        chk("crcbad_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk_cnts("crcbad");

        // Five good frames with rd_ready low: fifth is dropped
        do_reset();
        for (int i = 0; i < 5; i++) begin
            id = 11'(11'h100 + i);
            data = {$urandom(), $urandom()};
            send(mk_frame(id, 1'b0, 1'b0, 4'd8, data, -1));
            if (i < 4) model_frame(id, 1'b0, 4'd8, data, -1);
            else exp_drop++;
            repeat (83 + 1) tick();
        end
        chk("full_rd_valid", 64'(bus.rd_valid), 64'd1);
        chk_cnts("full");
        drain("full");

        // Same, but pop on the fifth frame's CHECK cycle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            id = 11'(11'h200 + i);
            data = {$urandom(), $urandom()};
            send(mk_frame(id, 1'b0, 1'b0, 4'd8, data, -1));
            model_frame(id, 1'b0, 4'd8, data, -1);
            if (i < 4) begin
                repeat (83 + 1) tick();
            end else begin
                repeat (83) tick();
                ready_force = 1'b1;
                ready_mode = 3;
                tick();
                ready_force = 1'b0;
                ready_mode = 0;
                tick();
            end
        end
        chk_cnts("full_pop");
        drain("full_pop");

        // Second strobe while busy
        do_reset();
        data = 64'h1122_3344_0000_0000;
        send(mk_frame(11'h055, 1'b0, 1'b0, 4'd4, data, -1));
        model_frame(11'h055, 1'b0, 4'd4, data, -1);
        repeat (4) tick();
        send(mk_frame(11'h7AA, 1'b0, 1'b0, 4'd1, 64'hFF00_0000_0000_0000, -1));
        exp_drop++;
        repeat (51 - 4) tick();
        chk_cnts("busy_drop");
        drain("busy_drop");

        // Reset mid-SHIFT discards the frame
        do_reset();
        send(mk_frame(11'h321, 1'b0, 1'b0, 4'd3, 64'hDEAD_BE00_0000_0000, -1));
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (50) tick();
        chk("rstmid_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk_cnts("rstmid");
        data = 64'hC0FF_EE00_0000_0000;
        send(mk_frame(11'h321, 1'b0, 1'b0, 4'd3, data, -1));
        model_frame(11'h321, 1'b0, 4'd3, data, -1);
        repeat (45) tick();
        chk("rstmid_next_rd_valid", 64'(bus.rd_valid), 64'd1);
        drain("rstmid_next");

`ifdef CAN_FRAME_BUFFER_FILTER_EN
        // Acceptance filter
        do_reset();
        flt_id = 11'h120;
        flt_mask = 11'h7F0;
        data = 64'h5A00_0000_0000_0000;
        send(mk_frame(11'h123, 1'b0, 1'b0, 4'd1, data, -1));
        model_frame(11'h123, 1'b0, 4'd1, data, -1);
        repeat (30) tick();
        send(mk_frame(11'h223, 1'b0, 1'b0, 4'd1, data, -1));
        model_frame(11'h223, 1'b0, 4'd1, data, -1);
        repeat (30) tick();
        chk_cnts("filter");
        drain("filter");
        flt_mask = '0;
`endif

        // Counter saturation: strobe held high against a bad-CRC 8-byte frame
        do_reset();
        f = mk_frame(11'h0F0, 1'b0, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, 3);
        strobes = 400;
        acc = 0;
        for (int c = 0; c < strobes; c++) if (c % (83 + 2) == 0) acc++;
        frame = f;
        frame_valid = 1'b1;
        repeat (strobes) tick();
        frame_valid = 1'b0;
        repeat (90) tick();
        exp_err  = acc;
        exp_drop = (strobes - acc > CNT_MAX) ? CNT_MAX : strobes - acc;
        chk_cnts("saturate");
        chk("saturate_rd_valid", 64'(bus.rd_valid), 64'd0);

        // Randomized traffic with a random consumer
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            b = 0;
            while (pending() >= DEPTH && b < 1000) begin
                tick();
                b++;
            end
            if (pending() >= DEPTH) begin
                n_chk++;
                n_fail++;
                $display("FAIL rand_wait_room: got %0d pending, required < %0d", pending(), DEPTH);
            end
            id   = 11'($urandom());
            rtr  = ($urandom_range(0, 5) == 0);
            dlc  = 4'($urandom());
            data = {$urandom(), $urandom()};
            bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
            send(mk_frame(id, rtr, 1'($urandom()), dlc, data, bad));
            model_frame(id, rtr, dlc, data, bad);
            n = 19 + 8 * data_len(rtr, dlc);
            repeat (n + 1 + int'($urandom_range(0, 3))) tick();
        end
        drain("random");
        chk_cnts("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk + m_chk, n_fail + m_fail);
        $finish;
    end

endmodule
